multicycle_controller: RTL

- Multi-cycle control FSM for the RISC core. Sequences fetch, decode, execute, memory and writeback over the shared datapath (IDecode, RegisterFile, Extender, ALU, unified memory port).
- Consumes the opcode/func fields from IDecode and the ALU zero flag.
- Drives every datapath enable, mux select and memory request, and configures the Extender's sign/zero mode per instruction.

---
 rtl/multicycle_controller.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RISC core.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over the shared datapath,
// driving every enable, mux select and memory request, and tracks retired
// instructions, halt and trap status.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   opcode, func           instruction fields from IDecode (latched in DECODE)
//   alu_zero               ALU result == 0 (beq decision in EXEC)
//   mem_ack                memory transfer complete
//   mem_req/mem_we/addr_sel  memory request, write, address select (0 PC, 1 ALU)
//   ir_load, pc_inc, pc_load, pc_src  IR and PC controls
//   reg_write, reg_dst, wb_sel        register file writeback controls
//   ext_sign, alu_src, alu_op         Extender mode and ALU configuration
//   halted, illegal        sticky halt / trap indications
//   retired                completed-instruction counter (wraps)
//   state                  current FSM state (debug)
module multicycle_controller #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             wb_sel,
    output logic             ext_sign,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((MEM_TIMEOUT == 0) ? 32'd0 : MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_HALT   = 3'b101,
        S_TRAP   = 3'b110
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, func_q, op_d, func_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             retire, req_ack, tmo_hit;

    logic             is_r, is_addi, is_andi, is_ori, is_lw, is_sw, is_beq, is_j;
    logic             r_ok, legal;
    logic [2:0]       aop_dec;
    logic             asrc_dec, esign_dec;

    logic             mem_req_d, mem_we_d, addr_sel_d, pc_src_d;
    logic             reg_write_d, reg_dst_d, wb_sel_d;
    logic             ext_sign_d, alu_src_d, halted_d, illegal_d;
    logic [2:0]       alu_op_d;

    // Raw fields are used while decoding; latched fields steer everything after.
    assign op_d   = (state_q == S_DECODE) ? opcode : op_q;
    assign func_d = (state_q == S_DECODE) ? func   : func_q;

    assign is_r    = (op_d == OP_RTYPE);
    assign is_addi = (op_d == OP_ADDI);
    assign is_andi = (op_d == OP_ANDI);
    assign is_ori  = (op_d == OP_ORI);
    assign is_lw   = (op_d == OP_LW);
    assign is_sw   = (op_d == OP_SW);
    assign is_beq  = (op_d == OP_BEQ);
    assign is_j    = (op_d == OP_J);

    // Instruction decode: legality plus ALU / Extender configuration.
    always_comb begin
        r_ok      = 1'b1;
        aop_dec   = ALU_ADD;
        asrc_dec  = 1'b0;
        esign_dec = 1'b0;
        case (op_d)
            OP_RTYPE: begin
                case (func_d)
                    FN_ADD:  aop_dec = ALU_ADD;
                    FN_SUB:  aop_dec = ALU_SUB;
                    FN_AND:  aop_dec = ALU_AND;
                    FN_OR:   aop_dec = ALU_OR;
                    FN_SLT:  aop_dec = ALU_SLT;
                    FN_SLL:  aop_dec = ALU_SLL;
                    default: r_ok    = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                asrc_dec  = 1'b1;
                esign_dec = 1'b1;
            end
            OP_ANDI: begin
                aop_dec  = ALU_AND;
                asrc_dec = 1'b1;
            end
            OP_ORI: begin
                aop_dec  = ALU_OR;
                asrc_dec = 1'b1;
            end
            OP_BEQ: begin
                aop_dec   = ALU_SUB;
                esign_dec = 1'b1;
            end
            default: ;
        endcase
        legal = (is_r && r_ok) || is_addi || is_andi || is_ori ||
                is_lw || is_sw || is_beq || is_j;
    end

    // Next-state, retire and memory-timeout logic.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        tmo_d   = '0;
        // An ack only counts while a request is actually outstanding.
        req_ack = mem_req && mem_ack;
        tmo_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ack && (tmo_q == TMO_LAST);
        case (state_q)
            S_FETCH: begin
                if (req_ack)      state_d = S_DECODE;
                else if (tmo_hit) state_d = S_TRAP;
            end
            S_DECODE: begin
                if (op_d == OP_HALT) state_d = S_HALT;
                else if (!legal)     state_d = S_TRAP;
                else                 state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_beq || is_j) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (req_ack) begin
                    if (is_sw) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (mem_req && !mem_ack && !tmo_hit && (state_d == state_q))
            tmo_d = tmo_q + 1'b1;
    end

    // Registered output values, derived from the state being entered.
    always_comb begin
        mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_we_d    = (state_d == S_MEM) && is_sw;
        addr_sel_d  = ((state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB)) &&
                      (is_lw || is_sw);
        reg_write_d = (state_d == S_WB);
        reg_dst_d   = (state_d == S_WB) && is_r;
        wb_sel_d    = (state_d == S_WB) && is_lw;
        halted_d    = halted || (state_d == S_HALT) || (state_d == S_TRAP);
        illegal_d   = illegal || (state_d == S_TRAP);
        // ALU / Extender setup loads on EXEC entry and holds through MEM and WB.
        alu_op_d    = alu_op;
        alu_src_d   = alu_src;
        ext_sign_d  = ext_sign;
        pc_src_d    = pc_src;
        if ((state_d == S_EXEC) && (state_q != S_EXEC)) begin
            alu_op_d   = aop_dec;
            alu_src_d  = asrc_dec;
            ext_sign_d = esign_dec;
            pc_src_d   = is_j;
        end
    end

    // Ack- and zero-qualified strobes must act in the cycle the condition occurs.
    assign ir_load = (state_q == S_FETCH) && mem_req && mem_ack;
    assign pc_inc  = ir_load;
    assign pc_load = (state_q == S_EXEC) && (is_j || (is_beq && alu_zero));
    assign state   = state_q;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            func_q    <= '0;
            tmo_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            addr_sel  <= 1'b0;
            pc_src    <= 1'b0;
            reg_write <= 1'b0;
            reg_dst   <= 1'b0;
            wb_sel    <= 1'b0;
            ext_sign  <= 1'b0;
            alu_src   <= 1'b0;
            alu_op    <= 3'b000;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            func_q    <= func_d;
            tmo_q     <= tmo_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            addr_sel  <= addr_sel_d;
            pc_src    <= pc_src_d;
            reg_write <= reg_write_d;
            reg_dst   <= reg_dst_d;
            wb_sel    <= wb_sel_d;
            ext_sign  <= ext_sign_d;
            alu_src   <= alu_src_d;
            alu_op    <= alu_op_d;
            halted    <= halted_d;
            illegal   <= illegal_d;
            if (retire) retired <= retired + 1'b1;
        end
    end

endmodule
